// File: rtl/id_ex_stage_pkg.sv
// Shared RV32I pipeline definitions: opcodes, ALU-op encoding, immediate types
// and the ID/EX control bundle.
package rv_pipe_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_SLL   = 4'd2;
   localparam logic [3:0] ALU_SLT   = 4'd3;
   localparam logic [3:0] ALU_SLTU  = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_OR    = 4'd8;
   localparam logic [3:0] ALU_AND   = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_type_e;

   typedef struct packed {
      logic       valid;
      logic       branch;
      logic       memread;
      logic       memtoreg;
      logic       memwrite;
      logic       alusrc;
      logic       regwrite;
      logic       illegal;
      logic [3:0] aluop;
   } ctrl_t;

   // Branches compare via subtraction; everything without an ALU function adds.
   function automatic logic [3:0] alu_op_enc(input logic [6:0] opc, input logic [2:0] f3,
                                             input logic b30);
      logic [3:0] op;
      op = ALU_ADD;
      case (opc)
         OPC_OP, OPC_OPIMM: begin
            case (f3)
               3'b000:  op = (opc == OPC_OP && b30) ? ALU_SUB : ALU_ADD;
               3'b001:  op = ALU_SLL;
               3'b010:  op = ALU_SLT;
               3'b011:  op = ALU_SLTU;
               3'b100:  op = ALU_XOR;
               3'b101:  op = b30 ? ALU_SRA : ALU_SRL;
               3'b110:  op = ALU_OR;
               default: op = ALU_AND;
            endcase
         end
         OPC_BRANCH: op = ALU_SUB;
         OPC_LUI:    op = ALU_PASSB;
         default:    op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// IF/ID, register-file, MEM/WB and ID/EX signal bundle for the decode stage.
interface id_ex_stage_if #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   logic              if_id_valid;
   logic [31:0]       if_id_instruction;
   logic [XLEN-1:0]   if_id_pc;
   logic              ex_flush;
   logic              ex_stall;
   logic [REG_AW-1:0] reg_read_addr_1, reg_read_addr_2;
   logic [XLEN-1:0]   reg_read_data_1, reg_read_data_2;
   logic [REG_AW-1:0] mem_wb_rd;
   logic [XLEN-1:0]   mem_wb_result;
   logic              mem_wb_regwrite;
   logic              id_stall;
   logic              id_ex_valid, id_ex_branch, id_ex_memread, id_ex_memtoreg;
   logic              id_ex_memwrite, id_ex_alusrc, id_ex_regwrite, id_ex_illegal;
   logic [3:0]        id_ex_aluop;
   logic [XLEN-1:0]   id_ex_imme, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data;
   logic [REG_AW-1:0] id_ex_rs1, id_ex_rs2, id_ex_rd;
   logic [CNT_W-1:0]  bubble_count;

   modport slave (
      input  if_id_valid, if_id_instruction, if_id_pc, ex_flush, ex_stall,
             reg_read_data_1, reg_read_data_2, mem_wb_rd, mem_wb_result, mem_wb_regwrite,
      output reg_read_addr_1, reg_read_addr_2, id_stall,
             id_ex_valid, id_ex_branch, id_ex_memread, id_ex_memtoreg, id_ex_memwrite,
             id_ex_alusrc, id_ex_regwrite, id_ex_illegal, id_ex_aluop, id_ex_imme, id_ex_pc,
             id_ex_rs1_data, id_ex_rs2_data, id_ex_rs1, id_ex_rs2, id_ex_rd, bubble_count
   );

   modport master (
      output if_id_valid, if_id_instruction, if_id_pc, ex_flush, ex_stall,
             reg_read_data_1, reg_read_data_2, mem_wb_rd, mem_wb_result, mem_wb_regwrite,
      input  reg_read_addr_1, reg_read_addr_2, id_stall,
             id_ex_valid, id_ex_branch, id_ex_memread, id_ex_memtoreg, id_ex_memwrite,
             id_ex_alusrc, id_ex_regwrite, id_ex_illegal, id_ex_aluop, id_ex_imme, id_ex_pc,
             id_ex_rs1_data, id_ex_rs2_data, id_ex_rs1, id_ex_rs2, id_ex_rd, bubble_count
   );
endinterface

// File: rtl/id_ex_stage_imm_gen.sv
// Immediate generator: assembles the 32-bit RV immediate for the given format
// and sign-extends it from instr[31] to XLEN.
module id_imm_gen
   import rv_pipe_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   input  imm_type_e       imm_type,
   output logic [XLEN-1:0] imm
);
   logic [31:0] raw;

   always_comb begin
      raw = '0;
      case (imm_type)
         IMM_I:   raw = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_J:   raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         IMM_U:   raw = {instr[31:12], 12'b0};
         default: raw = '0;
      endcase
   end

   assign imm = XLEN'($signed(raw));
endmodule

// File: rtl/id_ex_stage.sv
// RV32I decode stage with ID/EX pipeline register, load-use bubble insertion,
// MEM/WB bypass and a saturating bubble counter.
module id_ex_stage
   import rv_pipe_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int NUM_REGS     = 32,
   parameter bit UPPER_IMM_EN = 1'b1,
   parameter bit FWD_EN       = 1'b1,
   parameter int CNT_W        = 16,
   localparam int REG_AW      = $clog2(NUM_REGS)
) (
   input logic          clk,
   input logic          rst,
   id_ex_stage_if.slave bus
);
   logic [31:0]       instr;
   logic [6:0]        opcode;
   logic [REG_AW-1:0] rs1_a, rs2_a, rd_a;
   ctrl_t             dec_c;
   imm_type_e         imm_type;
   logic              rs1_used, rs2_used, hazard;
   logic [XLEN-1:0]   dec_imm, rs1_fwd, rs2_fwd;

   ctrl_t             ctrl_q, ctrl_d;
   logic [XLEN-1:0]   imme_q, imme_d, pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
   logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   assign instr  = bus.if_id_instruction;
   assign opcode = instr[6:0];
   assign rs1_a  = REG_AW'(instr[19:15]);
   assign rs2_a  = REG_AW'(instr[24:20]);
   assign rd_a   = REG_AW'(instr[11:7]);

   always_comb begin
      dec_c    = '0;
      imm_type = IMM_NONE;
      rs1_used = 1'b1;
      rs2_used = 1'b0;
      case (opcode)
         OPC_LOAD:   begin dec_c.memread = 1'b1; dec_c.memtoreg = 1'b1; dec_c.regwrite = 1'b1;
                           dec_c.alusrc = 1'b1; imm_type = IMM_I; end
         OPC_STORE:  begin dec_c.memwrite = 1'b1; dec_c.alusrc = 1'b1; imm_type = IMM_S;
                           rs2_used = 1'b1; end
         OPC_BRANCH: begin dec_c.branch = 1'b1; imm_type = IMM_B; rs2_used = 1'b1; end
         OPC_JAL:    begin dec_c.branch = 1'b1; dec_c.regwrite = 1'b1; imm_type = IMM_J;
                           rs1_used = 1'b0; end
         OPC_OP:     begin dec_c.regwrite = 1'b1; rs2_used = 1'b1; end
         OPC_OPIMM:  begin dec_c.regwrite = 1'b1; dec_c.alusrc = 1'b1; imm_type = IMM_I; end
         OPC_JALR: begin
            if (UPPER_IMM_EN) begin
               dec_c.branch = 1'b1; dec_c.regwrite = 1'b1; dec_c.alusrc = 1'b1; imm_type = IMM_I;
            end else dec_c.illegal = 1'b1;
         end
         OPC_LUI, OPC_AUIPC: begin
            if (UPPER_IMM_EN) begin
               dec_c.regwrite = 1'b1; dec_c.alusrc = 1'b1; imm_type = IMM_U; rs1_used = 1'b0;
            end else dec_c.illegal = 1'b1;
         end
         default: dec_c.illegal = 1'b1;
      endcase
      // Illegal words carry no control and never look like a register consumer.
      if (dec_c.illegal) begin
         rs1_used = 1'b0;
         rs2_used = 1'b0;
      end else begin
         dec_c.aluop = alu_op_enc(opcode, instr[14:12], instr[30]);
      end
      dec_c.valid = bus.if_id_valid;
   end

   id_imm_gen #(.XLEN(XLEN)) u_imm_gen (.instr(instr), .imm_type(imm_type), .imm(dec_imm));

   always_comb begin
      rs1_fwd = bus.reg_read_data_1;
      rs2_fwd = bus.reg_read_data_2;
      if (rs1_a == '0) rs1_fwd = '0;
      else if (FWD_EN && bus.mem_wb_regwrite && bus.mem_wb_rd == rs1_a) rs1_fwd = bus.mem_wb_result;
      if (rs2_a == '0) rs2_fwd = '0;
      else if (FWD_EN && bus.mem_wb_regwrite && bus.mem_wb_rd == rs2_a) rs2_fwd = bus.mem_wb_result;
   end

   assign hazard = bus.if_id_valid & ctrl_q.valid & ctrl_q.memread & (rd_q != '0) &
                   (((rd_q == rs1_a) & rs1_used) | ((rd_q == rs2_a) & rs2_used));

   assign bus.id_stall        = bus.ex_stall | (hazard & ~bus.ex_flush);
   assign bus.reg_read_addr_1 = rs1_a;
   assign bus.reg_read_addr_2 = rs2_a;

   // Flush and bubble both clear the whole register; only a load-use bubble counts.
   always_comb begin
      ctrl_d = ctrl_q; imme_d = imme_q; pc_d = pc_q;
      rs1_data_d = rs1_data_q; rs2_data_d = rs2_data_q;
      rs1_d = rs1_q; rs2_d = rs2_q; rd_d = rd_q; cnt_d = cnt_q;
      if (bus.ex_flush || (!bus.ex_stall && hazard)) begin
         ctrl_d = '0; imme_d = '0; pc_d = '0; rs1_data_d = '0; rs2_data_d = '0;
         rs1_d = '0; rs2_d = '0; rd_d = '0;
         if (!bus.ex_flush && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
      end else if (!bus.ex_stall) begin
         ctrl_d = dec_c; imme_d = dec_imm; pc_d = bus.if_id_pc;
         rs1_data_d = rs1_fwd; rs2_data_d = rs2_fwd;
         rs1_d = rs1_a; rs2_d = rs2_a; rd_d = rd_a;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q <= '0; imme_q <= '0; pc_q <= '0; rs1_data_q <= '0; rs2_data_q <= '0;
         rs1_q <= '0; rs2_q <= '0; rd_q <= '0; cnt_q <= '0;
      end else begin
         ctrl_q <= ctrl_d; imme_q <= imme_d; pc_q <= pc_d;
         rs1_data_q <= rs1_data_d; rs2_data_q <= rs2_data_d;
         rs1_q <= rs1_d; rs2_q <= rs2_d; rd_q <= rd_d; cnt_q <= cnt_d;
      end
   end

   assign bus.id_ex_valid    = ctrl_q.valid;
   assign bus.id_ex_branch   = ctrl_q.branch;
   assign bus.id_ex_memread  = ctrl_q.memread;
   assign bus.id_ex_memtoreg = ctrl_q.memtoreg;
   assign bus.id_ex_memwrite = ctrl_q.memwrite;
   assign bus.id_ex_alusrc   = ctrl_q.alusrc;
   assign bus.id_ex_regwrite = ctrl_q.regwrite;
   assign bus.id_ex_illegal  = ctrl_q.illegal;
   assign bus.id_ex_aluop    = ctrl_q.aluop;
   assign bus.id_ex_imme     = imme_q;
   assign bus.id_ex_pc       = pc_q;
   assign bus.id_ex_rs1_data = rs1_data_q;
   assign bus.id_ex_rs2_data = rs2_data_q;
   assign bus.id_ex_rs1      = rs1_q;
   assign bus.id_ex_rs2      = rs2_q;
   assign bus.id_ex_rd       = rd_q;
   assign bus.bubble_count   = cnt_q;
endmodule
